// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: request codes, PIDs, FSM states and CRC constants for usb_tx_encoder
package usb_tx_pkg;
    localparam logic [3:0] TXP_NONE  = 4'd0;
    localparam logic [3:0] TXP_DATA0 = 4'd1;
    localparam logic [3:0] TXP_DATA1 = 4'd2;
    localparam logic [3:0] TXP_ACK   = 4'd3;
    localparam logic [3:0] TXP_NAK   = 4'd4;
    localparam logic [3:0] TXP_STALL = 4'd5;

    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J} tx_state_e;

    function automatic logic [3:0] pid_of(input logic [3:0] code);
        return (code == TXP_DATA0) ? PID_DATA0 :
               (code == TXP_DATA1) ? PID_DATA1 :
               (code == TXP_ACK)   ? PID_ACK   :
               (code == TXP_NAK)   ? PID_NAK   : PID_STALL;
    endfunction
endpackage

// File: rtl/usb_tx_crc16.sv
// usb_tx_crc16: serial CRC16 (poly 0x8005, init 0xFFFF) over bits in wire order
// Ports: clk, n_rst (async active-low), clear (reload init), bit_valid/bit_in (one
// payload bit per strobe), crc (current remainder).
module usb_tx_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic [15:0] crc
);
    logic [15:0] crc_q, crc_d;
    logic        fb;

    always_comb begin
        fb    = crc_q[15] ^ bit_in;
        crc_d = clear     ? CRC16_INIT :
                bit_valid ? ({crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000)) : crc_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) crc_q <= CRC16_INIT;
        else        crc_q <= crc_d;
    end

    assign crc = crc_q;
endmodule

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB full-speed packet transmitter (SYNC, PID, payload, CRC16, EOP)
// with bit stuffing and NRZI line coding.
// Ports: clk, n_rst (async active-low); tx_packet request code and buffer_occupancy
// sampled in IDLE; tx_packet_data byte returned the clock after get_tx_packet_data;
// tx_transfer_active while on the wire; tx_error pulse on rejected request;
// dp_out/dm_out line drive.
// Option: define USB_TX_CRC16_EN to append CRC16 to data packets.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64,
    parameter int OCC_W        = $clog2(MAX_BYTES + 2)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [3:0]       tx_packet,
    input  logic [OCC_W-1:0] buffer_occupancy,
    input  logic [7:0]       tx_packet_data,
    output logic             get_tx_packet_data,
    output logic             tx_transfer_active,
    output logic             tx_error,
    output logic             dp_out,
    output logic             dm_out
);
    localparam int            TW   = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic [OCC_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [2:0]       ones_q, ones_d;
    logic [3:0]       pid_q, pid_d;
    logic             line_q, line_d;
    logic             get_q, get_d;
    logic             getd_q, getd_d;
    logic             err_q, err_d;
    logic             active_q, active_d;
    logic             tick, send, nb, req_data;
`ifdef USB_TX_CRC16_EN
    logic             crc_hi_q, crc_hi_d;
    logic             crc_clr, crc_valid;
    logic [15:0]      crc_rem;

    usb_tx_crc16 u_crc (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (crc_clr),
        .bit_valid (crc_valid),
        .bit_in    (nb),
        .crc       (crc_rem)
    );
`endif

    assign req_data = (tx_packet == TXP_DATA0) || (tx_packet == TXP_DATA1);
    assign tick     = (timer_q == '0);

    always_comb begin
        state_d    = state_q;
        timer_d    = (state_q == IDLE || tick) ? TMAX : timer_q - 1'b1;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        ones_d     = ones_q;
        pid_d      = pid_q;
        line_d     = line_q;
        data_d     = getd_q ? tx_packet_data : data_q;
        getd_d     = get_q;
        get_d      = 1'b0;
        err_d      = 1'b0;
        send       = 1'b0;
        nb         = 1'b0;
`ifdef USB_TX_CRC16_EN
        crc_hi_d   = crc_hi_q;
        crc_clr    = 1'b0;
        crc_valid  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (tx_packet != TXP_NONE) begin
                    if (tx_packet > TXP_STALL || (req_data && int'(buffer_occupancy) > MAX_BYTES)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = SYNC;
                        bit_idx_d  = 3'd0;
                        shreg_d    = SYNC_BYTE;
                        pid_d      = pid_of(tx_packet);
                        byte_cnt_d = req_data ? buffer_occupancy : '0;
                        ones_d     = 3'd0;
                        // first SYNC bit is a 0, so the line toggles from J to K
                        line_d     = 1'b0;
`ifdef USB_TX_CRC16_EN
                        crc_clr    = 1'b1;
                        crc_hi_d   = 1'b0;
`endif
                    end
                end
            end
            EOP_SE0: begin
                if (tick) begin
                    bit_idx_d = 3'd1;
                    if (bit_idx_q[0]) state_d = EOP_J;
                end
            end
            EOP_J: begin
                if (tick) state_d = IDLE;
            end
            default: begin
                if (tick) begin
                    if (ones_q == 3'd6) begin
                        // stuff bit: bit index holds so the next tick resumes the byte
                        ones_d = 3'd0;
                        line_d = ~line_q;
                    end else begin
                        send = 1'b1;
                        if (bit_idx_q != 3'd7) begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end else begin
                            bit_idx_d = 3'd0;
                            if (state_q == SYNC) begin
                                state_d = PID;
                                shreg_d = {~pid_q, pid_q};
                            end else if (byte_cnt_q != '0) begin
                                state_d    = DATA;
                                shreg_d    = data_q;
                                byte_cnt_d = byte_cnt_q - 1'b1;
                            end
`ifdef USB_TX_CRC16_EN
                            // data PIDs are the only ones with low bits 2'b11
                            else if (state_q != CRC && pid_q[1:0] == 2'b11) begin
                                state_d = CRC;
                                shreg_d = ~crc_rem[7:0];
                            end else if (state_q == CRC && !crc_hi_q) begin
                                crc_hi_d = 1'b1;
                                shreg_d  = ~crc_rem[15:8];
                            end
`endif
                            else begin
                                state_d = EOP_SE0;
                                send    = 1'b0;
                            end
                        end
                        if (send) begin
                            nb     = shreg_d[bit_idx_d];
                            line_d = nb ? line_q : ~line_q;
                            ones_d = nb ? ones_q + 3'd1 : 3'd0;
                            // fetch the next byte at the start of the last bit of this one
                            get_d  = (bit_idx_d == 3'd7) && (state_d == PID || state_d == DATA) &&
                                     (byte_cnt_d != '0);
`ifdef USB_TX_CRC16_EN
                            crc_valid = (state_d == DATA);
`endif
                        end
                    end
                end
            end
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            timer_q    <= TMAX;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'h00;
            data_q     <= 8'h00;
            byte_cnt_q <= '0;
            ones_q     <= 3'd0;
            pid_q      <= 4'h0;
            line_q     <= 1'b1;
            get_q      <= 1'b0;
            getd_q     <= 1'b0;
            err_q      <= 1'b0;
            active_q   <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc_hi_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            byte_cnt_q <= byte_cnt_d;
            ones_q     <= ones_d;
            pid_q      <= pid_d;
            line_q     <= line_d;
            get_q      <= get_d;
            getd_q     <= getd_d;
            err_q      <= err_d;
            active_q   <= active_d;
`ifdef USB_TX_CRC16_EN
            crc_hi_q   <= crc_hi_d;
`endif
        end
    end

    assign dp_out             = (state_q == IDLE || state_q == EOP_J) ? 1'b1 :
                                (state_q == EOP_SE0) ? 1'b0 : line_q;
    assign dm_out             = (state_q == IDLE || state_q == EOP_J || state_q == EOP_SE0) ? 1'b0 : ~line_q;
    assign get_tx_packet_data = get_q;
    assign tx_error           = err_q;
    assign tx_transfer_active = active_q;
endmodule

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

Parametrised USB full-speed transmit encoder. It accepts a packet request from the protocol layer, fetches payload bytes from the TX buffer, and emits the complete packet on the differential pair. Each packet is SYNC, PID, payload, CRC16 and EOP, with bit stuffing and NRZI encoding. It sits between the TX FIFO and the DP/DM pad drivers and supersedes the fixed-width transmit path.

## Interface
- CLKS_PER_BIT, default 8: system clocks per USB bit period; minimum 4.
- MAX_BYTES, default 64: maximum data-packet payload length.
- OCC_W, default $clog2(MAX_BYTES+2): width of buffer_occupancy.
- clk  in  1  system clock.
- n_rst  in  1  reset; one clock, asynchronous, active-low.
- tx_packet  in  4  request code: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, others illegal.
- buffer_occupancy  in  OCC_W  payload bytes available; sampled with the request.
- tx_packet_data  in  8  payload byte; valid the clock after get_tx_packet_data.
- get_tx_packet_data  out  1  one-clock byte fetch strobe.
- tx_transfer_active  out  1  high while a packet is on the wire.
- tx_error  out  1  one-clock pulse on a rejected request.
- dp_out, dm_out  out  1 each  line drive.

## Operation
- States: IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J.
- Bit timer: a counter counts CLKS_PER_BIT-1 down to 0. bit_tick fires at 0 and advances to the next line bit.
- IDLE:
  - Drives J (dp=1, dm=0).
  - A nonzero tx_packet is sampled on a clock edge and enters SYNC.
  - For data PIDs, buffer_occupancy is latched as byte_count.
- Rejected requests: illegal code, or data PID with byte_count > MAX_BYTES.
  - tx_error pulses for one clock and the block stays in IDLE.
  - No line activity occurs.
- While not in IDLE, tx_packet is ignored.
- SYNC sends 0x80 and PID sends {~pid, pid}. Every byte is sent LSB first.
- Handshake PIDs go from PID directly to EOP_SE0.
- DATA sends byte_count bytes; byte_count = 0 skips DATA.
- Byte fetch:
  - get_tx_packet_data pulses on the first clock of the last bit period of the preceding byte (PID or previous DATA byte).
  - The byte is registered on the following clock.
- CRC:
  - CRC16, polynomial 0x8005, initial value 0xFFFF, computed over payload bits only.
  - The complement of the result is sent LSB first: low byte, then high byte.
- Bit stuffing:
  - A ones counter covers SYNC through CRC.
  - After six consecutive 1s, one 0 bit is inserted and the counter clears.
  - A stuff bit due after the final CRC bit is sent before EOP.
  - The counter resets at packet start.
- NRZI: data 0 toggles the line state; data 1 holds it. The line starts from J.
- EOP: two bit periods SE0 (dp=0, dm=0), then one bit period J, then back to IDLE.

## Timing
- Reset values: dp_out=1, dm_out=0, tx_transfer_active=0, tx_error=0, get_tx_packet_data=0, state IDLE.
- Asynchronous reset mid-packet aborts immediately to these values.
- The first SYNC bit appears on the clock after the request is sampled; tx_transfer_active rises on that same clock.
- tx_transfer_active falls on the clock the final J bit period ends.
- The next request is accepted on that same clock.
- Total active clocks = (16 + 8·n + 16·crc + stuff_bits + 3)·CLKS_PER_BIT.
  - crc = 1 for data packets, 0 for handshakes.
  - n is the payload byte count.
- tx_error asserts on the clock after the rejected request is sampled.

## Configuration
- USB_TX_CRC16_EN defined: CRC16 generated and appended to data packets as above.
- USB_TX_CRC16_EN undefined:
  - The CRC state is skipped and no CRC logic is built.
  - Data packets go DATA→EOP_SE0, 16 bits shorter.
  - Intended only for link-level bring-up.

## Structure
- Package usb_tx_pkg:
  - tx_packet request codes and 4-bit PID constants (DATA0 0x3, DATA1 0xB, ACK 0x2, NAK 0xA, STALL 0xE).
  - State enum.
  - SYNC_BYTE 0x80.
  - CRC16 polynomial and init constants.
- Sub-module usb_tx_crc16: serial CRC with clear, bit_valid and bit_in inputs and a 16-bit remainder output. It is instantiated only under USB_TX_CRC16_EN.

## Test plan
- ACK (tx_packet=3): 16 data bits SYNC 0x80 then PID 0xD2 NRZI-encoded, no stuffing, 2 SE0 + 1 J; tx_transfer_active high exactly 19·CLKS_PER_BIT clocks.
- DATA0, occupancy 0: PID 0xC3, no get_tx_packet_data pulses, CRC bytes 0x00 0x00 on the wire, EOP.
- DATA1, occupancy 1, byte 0xFF: PID 0x4B, one get pulse, a 0 stuffed after the sixth payload 1, remaining two 1s, then CRC; active length includes the extra bit.
- Occupancy 65 with MAX_BYTES=64, DATA0: tx_error high one clock, dp/dm held J, tx_transfer_active stays 0.
- tx_packet=7: tx_error pulse, no transmission.
- n_rst asserted mid-DATA: outputs return to reset values in the same clock; a new ACK request afterwards transmits correctly.
